// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader.
// Contents:
//   - loader FSM state encoding (3-bit localparams)
//   - INSTR_W    : instruction word width
//   - IMEM_DEPTH : number of instruction words in memory
//   - instr_t    : instruction word type
package mips_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] COUNT = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERR   = 3'd6;

    localparam int INSTR_W    = 32;
    localparam int IMEM_DEPTH = 9;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: host byte stream, instruction-memory write port and status.
// Handshake: a byte transfers on a posedge where byte_valid && byte_ready are
// both high; byte_ready depends only on loader state, never on byte_valid.
// Signals:
//   start                      host -> loader, one-cycle load request
//   byte_in, byte_valid        host -> loader, stream byte
//   byte_ready                 loader -> host, byte can be accepted
//   wr_en, wr_addr, wr_data    loader -> imem, one-cycle write strobe
//   core_run, load_err         loader -> system status
// Modports: master = host/testbench side, slave = loader side.
interface imem_loader_if #(
    parameter int ADDR_W = 4
);
    import mips_pkg::*;

    logic              start;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    instr_t            wr_data;
    logic              core_run;
    logic              load_err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, wr_en, wr_addr, wr_data, core_run, load_err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, wr_en, wr_addr, wr_data, core_run, load_err
    );

endinterface

// File: rtl/word_assembler.sv
// Packs four stream bytes into one big-endian 32-bit word.
// Ports:
//   clock, reset   posedge clock, synchronous active-low reset
//   clear          restart byte position at the first (MSB) byte
//   shift_en       a byte is being accepted this cycle
//   byte_in        accepted byte
//   word           assembled word; valid while word_ready is high
//   word_ready     this cycle's byte completes a word
module word_assembler
    import mips_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift_en,
    input  logic [7:0] byte_in,
    output instr_t     word,
    output logic       word_ready
);

    // Only the first three bytes need storage: the fourth is taken straight
    // from byte_in so the word is available in the cycle it completes.
    logic [23:0] shreg;
    logic [1:0]  byte_cnt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (shift_en) begin
            shreg    <= {shreg[15:0], byte_in};
            byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after the 4th byte
        end
    end

    assign word       = {shreg, byte_in};
    assign word_ready = shift_en && (byte_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a count byte N followed by 4*N data bytes,
// writes N big-endian words to imem from address 0, then releases the core.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte (8-bit
// sum of all data bytes) that must match before the core is released.
// Ports:
//   clock, reset   posedge clock, synchronous active-low reset
//   bus            imem_loader_if.slave (stream, write port, status)
//   dbg_state      current FSM state
module imem_loader
    import mips_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = IMEM_DEPTH
)(
    input  logic              clock,
    input  logic              reset,
    imem_loader_if.slave      bus,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] word_idx;
    logic [ADDR_W-1:0] last_idx;
    logic              ready;
    logic              accept;
    logic              count_bad;
    logic              word_ready;
    instr_t            asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        sum;
`endif

    always_comb begin
        ready = (state == COUNT) || (state == DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        ready = ready || (state == CHECK);
`endif
    end

    assign accept         = bus.byte_valid && ready;
    assign count_bad      = (bus.byte_in == 8'd0) || (bus.byte_in > 8'(DEPTH));
    assign bus.byte_ready = ready;
    assign bus.wr_en      = (state == WRITE);
    assign bus.load_err   = (state == ERR);
    assign dbg_state      = state;

    word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (state == COUNT),
        .shift_en   (accept && (state == DATA)),
        .byte_in    (bus.byte_in),
        .word       (asm_word),
        .word_ready (word_ready)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            word_idx     <= '0;
            last_idx     <= '0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.core_run <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
        end else begin
            // Registered release: rises one cycle after entering DONE and
            // drops in the cycle after a restart is requested.
            bus.core_run <= (state == DONE) && !bus.start;

            case (state)
                IDLE: begin
                    if (bus.start) state <= COUNT;
                end
                COUNT: begin
                    if (accept) begin
                        if (count_bad) begin
                            state <= ERR;
                        end else begin
                            last_idx <= ADDR_W'(bus.byte_in - 8'd1);
                            word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            sum      <= '0;
`endif
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum <= sum + bus.byte_in;
`endif
                        if (word_ready) begin
                            // Address/data are captured here and held
                            // afterwards, so they stay stable outside WRITE.
                            bus.wr_addr <= word_idx;
                            bus.wr_data <= asm_word;
                            state       <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (word_idx == last_idx) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= CHECK;
`else
                        state <= DONE;
`endif
                    end else begin
                        state <= DATA;
                    end
                end
                CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (accept) state <= (bus.byte_in == sum) ? DONE : ERR;
`else
                    state <= IDLE;   // unreachable without the checksum stage
`endif
                end
                DONE, ERR: begin
                    if (bus.start) state <= COUNT;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed scenarios plus randomized loads,
// with a stream-level reference model producing the expected write sequence
// and final status.
module tb_imem_loader;
    import mips_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] dbg_state;

    imem_loader_if #(.ADDR_W(4)) bus ();

    imem_loader #(.ADDR_W(4), .DEPTH(9)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clock = ~clock;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int DONE_LAT = 1;
`else
    localparam int DONE_LAT = 2;
`endif

    int          n_vec    = 0;
    int          n_err    = 0;
    int          n_writes = 0;
    int          exp_nw   = 0;
    bit          exp_done = 1'b0;
    logic [35:0] exp_q[$];
    logic [7:0]  stream[$];

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Compare process: every write strobe must match the head of the expected queue.
    always @(negedge clock) begin
        if (bus.wr_en !== 1'b0) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h, expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                check("write", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
            end
            check("ready_in_write", {35'd0, bus.byte_ready}, 36'd0);
        end
        if (bus.core_run === 1'b1 && bus.load_err === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL status_exclusive: got core_run=1 load_err=1, expected at most one");
        end
    end

    // Reference model: derive writes and outcome from the byte stream.
    function automatic void build_model();
        int         n;
        logic [7:0] s;
        n = int'(stream[0]);
        s = 8'd0;
        if (n == 0 || n > IMEM_DEPTH) begin
            exp_done = 1'b0;
            exp_nw   = 0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({4'(w), stream[1+4*w], stream[2+4*w], stream[3+4*w], stream[4+4*w]});
            for (int k = 1; k <= 4; k++) s = s + stream[4*w+k];
        end
        exp_nw = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_done = (stream[1+4*n] == s);
`else
        exp_done = 1'b1;
`endif
    endfunction

    task automatic append_sum(input bit good);
        logic [7:0] s;
        s = 8'd0;
        for (int i = 1; i < stream.size(); i++) s = s + stream[i];
        if (!good) s = s + 8'($urandom_range(255, 1));
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(s);
`endif
    endtask

    task automatic make_random(input int n, input bit good);
        stream.delete();
        stream.push_back(8'(n));
        if (n >= 1 && n <= IMEM_DEPTH) begin
            for (int i = 0; i < 4*n; i++) stream.push_back(8'($urandom));
            append_sum(good);
        end
    endtask

    task automatic start_pulse();
        bus.byte_valid = 1'b0;
        bus.start      = 1'b1;
        @(negedge clock);
        bus.start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int t;
        gap = $urandom_range(max_gap, 0);
        if (gap > 0) begin
            bus.byte_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        t = 0;
        while (bus.byte_ready !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_timeout: got byte_ready low for 100 cycles, expected high (byte 0x%02h)", b);
        end
        @(negedge clock);   // transfer happens on the posedge just passed
    endtask

    task automatic wait_status(output int lat);
        lat = 0;
        while (!(bus.core_run === 1'b1 || bus.load_err === 1'b1) && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 40) begin
            n_vec++;
            n_err++;
            $display("FAIL status_timeout: got no core_run/load_err in 40 cycles, expected one");
        end
    endtask

    // Run one load from the current stream; the model must already be built.
    task automatic run_load(input int max_gap, input bit hold_after, output int lat);
        int n0;
        n0 = n_writes;
        start_pulse();
        foreach (stream[i]) send_byte(stream[i], max_gap);
        if (hold_after) begin
            bus.byte_in    = 8'($urandom);
            bus.byte_valid = 1'b1;   // must be ignored once the load is over
        end else begin
            bus.byte_valid = 1'b0;
        end
        wait_status(lat);
        repeat (2) @(negedge clock);
        bus.byte_valid = 1'b0;
        check("status", {34'd0, bus.core_run, bus.load_err}, exp_done ? 36'd2 : 36'd1);
        check("write_count", 36'(n_writes - n0), 36'(exp_nw));
        check("queue_drained", 36'(exp_q.size()), 36'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int lat;
        int n;
        bus.start      = 1'b0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready",    {35'd0, bus.byte_ready}, 36'd0);
        check("rst_wr_en",    {35'd0, bus.wr_en},      36'd0);
        check("rst_wr_bus",   {bus.wr_addr, bus.wr_data}, 36'd0);
        check("rst_status",   {34'd0, bus.core_run, bus.load_err}, 36'd0);
        reset = 1'b1;
        @(negedge clock);

        // Basic load
        stream = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h26);
`endif
        build_model();
        check("pin_w0", exp_q[0], 36'h0_20010005);
        check("pin_w1", exp_q[1], 36'h1_00000000);
        run_load(0, 1'b0, lat);
        check("done_latency", 36'(lat), 36'(DONE_LAT));

        // Bad counts, then recovery with N=1
        stream = '{8'h00};
        build_model();
        run_load(1, 1'b0, lat);
        check("err_latency", 36'(lat), 36'd0);
        stream = '{8'h0A};
        build_model();
        run_load(0, 1'b1, lat);
        make_random(1, 1'b1);
        build_model();
        run_load(2, 1'b0, lat);

        // Reset in the middle of word 1
        make_random(2, 1'b1);
        build_model();
        start_pulse();
        for (int i = 0; i < 7; i++) send_byte(stream[i], 1);
        bus.byte_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("midrst_ready",  {35'd0, bus.byte_ready}, 36'd0);
        check("midrst_wr_en",  {35'd0, bus.wr_en},      36'd0);
        check("midrst_wr_bus", {bus.wr_addr, bus.wr_data}, 36'd0);
        check("midrst_status", {34'd0, bus.core_run, bus.load_err}, 36'd0);
        check("midrst_pending", 36'(exp_q.size()), 36'd1);
        exp_q.delete();
        n = n_writes;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        check("midrst_no_write", 36'(n_writes - n), 36'd0);
        make_random(3, 1'b1);
        build_model();
        run_load(2, 1'b0, lat);

        // Full depth, then restart from DONE
        stream.delete();
        stream.push_back(8'h09);
        for (int w = 1; w <= 9; w++) begin
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'(w));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        stream.push_back(8'h2D);
`endif
        build_model();
        check("pin_last", exp_q[8], 36'h8_00000009);
        run_load(1, 1'b1, lat);
        check("last_wr_bus", {bus.wr_addr, bus.wr_data}, 36'h8_00000009);
        start_pulse();
        check("restart_drop", {35'd0, bus.core_run}, 36'd0);
        send_byte(8'h00, 0);   // now in COUNT: zero count must fail
        bus.byte_valid = 1'b0;
        check("restart_err", {34'd0, bus.core_run, bus.load_err}, 36'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        stream = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        build_model();
        check("pin_sum_ok", {35'd0, exp_done}, 36'd1);
        run_load(0, 1'b0, lat);
        stream = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
        build_model();
        check("pin_sum_bad", {35'd0, exp_done}, 36'd0);
        run_load(0, 1'b0, lat);
`endif

        // Randomized loads
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(5, 0) == 0)
                n = ($urandom_range(1, 0) == 0) ? 0 : $urandom_range(255, 10);
            else
                n = $urandom_range(9, 1);
            make_random(n, $urandom_range(3, 0) != 0);
            build_model();
            run_load($urandom_range(3, 0), 1'($urandom_range(1, 0)), lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
